// File: rtl/ring_osc_pkg.sv
// Shared definitions for the multi-channel ring-oscillator frequency counter:
// FSM state encodings, synchroniser depth floor and result-packing helper.
`timescale 1ns/1ps
package ring_osc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_MEASURE = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

    localparam int MIN_SYNC_STAGES = 2;

    // Lowest bit of channel ch inside a packed multi-channel result bus.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Synchroniser for one asynchronous ring-oscillator output followed by a
// rising-edge detector producing a single-cycle pulse per edge.
`timescale 1ns/1ps
module ring_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ring,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], ring};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse = sync[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/ring_osc_freq_counter.sv
// Multi-channel ring-oscillator frequency counter: counts synchronised rising
// edges per channel over a programmable gate window, single-shot or continuous.
`timescale 1ns/1ps
module ring_osc_freq_counter
    import ring_osc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ring_in,
    input  logic [GATE_W-1:0]       gate_len,
    input  logic                    start,
    input  logic                    continuous,
    output logic                    busy,
    output logic [NUM_CH*CNT_W-1:0] value_out,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    valid
);

    localparam int SYNC_EFF = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [GATE_W-1:0]       gate_cnt;
    logic [GATE_W-1:0]       gate_load;
    logic [NUM_CH-1:0]       pulse;
    logic [NUM_CH-1:0]       ovf_run;
    logic [NUM_CH-1:0]       ovf_nxt;
    logic [CNT_W-1:0]        cnt     [NUM_CH];
    logic [CNT_W-1:0]        cnt_nxt [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] value_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ring_edge_sync #(.SYNC_STAGES(SYNC_EFF)) u_sync (
            .clk   (clk),
            .rst   (rst),
            .ring  (ring_in[g]),
            .pulse (pulse[g])
        );
    end

    // A zero-length request still yields a one-cycle window.
    assign gate_load = (gate_len == '0) ? GATE_ONE : gate_len;
    assign busy      = (state != ST_IDLE);

    // Saturating per-channel count including this cycle's pulse; the sticky
    // flag marks any edge that arrived while the counter was already full.
    always_comb begin
        value_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            ovf_nxt[i] = ovf_run[i];
            if (pulse[i]) begin
                if (cnt[i] == CNT_MAX) ovf_nxt[i] = 1'b1;
                else                   cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
            value_nxt[ch_lsb(i, CNT_W) +: CNT_W] = cnt_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gate_cnt  <= '0;
            valid     <= 1'b0;
            value_out <= '0;
            overflow  <= '0;
            ovf_run   <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_MEASURE;
                        gate_cnt <= gate_load;
                        ovf_run  <= '0;
                        for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                    end
                end
                ST_MEASURE: begin
                    ovf_run  <= ovf_nxt;
                    gate_cnt <= gate_cnt - GATE_ONE;
                    for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
                    if (gate_cnt == GATE_ONE) begin
                        value_out <= value_nxt;
                        overflow  <= ovf_nxt;
                        valid     <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (continuous) begin
                        state    <= ST_MEASURE;
                        gate_cnt <= gate_load;
                        ovf_run  <= '0;
                        for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Scoreboard bench for ring_osc_freq_counter: directed windows push expected
// results, a negedge monitor pops and compares on every valid strobe.
`timescale 1ns/1ps
module tb_ring_osc_freq_counter;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 8;
    localparam int GATE_W      = 16;
    localparam int SYNC_STAGES = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       ring_in;
    logic [GATE_W-1:0]       gate_len;
    logic                    start;
    logic                    continuous;
    logic                    busy;
    logic [NUM_CH*CNT_W-1:0] value_out;
    logic [NUM_CH-1:0]       overflow;
    logic                    valid;

    ring_osc_freq_counter #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .ring_in(ring_in), .gate_len(gate_len),
        .start(start), .continuous(continuous), .busy(busy),
        .value_out(value_out), .overflow(overflow), .valid(valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_CH*CNT_W-1:0] val;
        logic [NUM_CH-1:0]       ovf;
        int                      cyc;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid=1 value_out=%0h, expected no strobe (cycle %0d)",
                         value_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("valid_cycle", 64'(cyc), 64'(e.cyc));
                check("value_out", 64'(value_out), 64'(e.val));
                check("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    // Ring stimulus: channel toggles every hp[ch] clk cycles, hp=0 holds it low.
    int hp[NUM_CH];
    int ph[NUM_CH];
    initial begin
        ring_in = '0;
        for (int i = 0; i < NUM_CH; i++) begin hp[i] = 0; ph[i] = 0; end
        forever begin
            @(posedge clk);
            #1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (hp[ch] == 0) begin
                    ring_in[ch] = 1'b0;
                    ph[ch] = 0;
                end else begin
                    ph[ch]++;
                    if (ph[ch] >= hp[ch]) begin
                        ph[ch] = 0;
                        ring_in[ch] = ~ring_in[ch];
                    end
                end
            end
        end
    end

    function automatic logic [NUM_CH*CNT_W-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
    endfunction

    task automatic set_pattern(input int h0, input int h1, input int h2, input int h3);
        hp[0] = h0; hp[1] = h1; hp[2] = h2; hp[3] = h3;
        repeat (8) @(posedge clk);
    endtask

    task automatic issue(input int g, input logic [NUM_CH*CNT_W-1:0] val,
                         input logic [NUM_CH-1:0] ovf, input int nwin, output int c);
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        gate_len = GATE_W'(g);
        start    = 1'b1;
        c        = cyc;
        n        = (g == 0) ? 1 : g;
        for (int k = 1; k <= nwin; k++) begin
            e.val = val;
            e.ovf = ovf;
            e.cyc = c + k * (n + 1);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && q.size() != 0; i++) @(negedge clk);
        check("drain_pending", 64'(q.size()), 64'd0);
    endtask

    int c;

    initial begin
        rst        = 1'b1;
        gate_len   = '0;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_value", 64'(value_out), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);

        // Single-shot, edge every 4 cycles on ch0.
        set_pattern(2, 0, 0, 0);
        issue(100, pack(25, 0, 0, 0), 4'b0000, 1, c);
        wait_until(c + 101);
        check("busy_in_done", 64'(busy), 64'd1);
        wait_until(c + 102);
        check("busy_after_done", 64'(busy), 64'd0);
        drain(50);
        repeat (5) @(negedge clk);
        check("value_hold", 64'(value_out), 64'(pack(25, 0, 0, 0)));

        // start and gate_len changes during a running window are ignored.
        issue(100, pack(25, 0, 0, 0), 4'b0000, 1, c);
        wait_until(c + 30);
        @(posedge clk);
        #1;
        start = 1'b1;
        gate_len = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(200);
        repeat (20) @(negedge clk);
        check("busy_after_ignore", 64'(busy), 64'd0);

        // Saturation on ch1, then a short window clears the flag.
        set_pattern(0, 1, 0, 0);
        issue(600, pack(0, 255, 0, 0), 4'b0010, 1, c);
        drain(700);
        issue(10, pack(0, 5, 0, 0), 4'b0000, 1, c);
        drain(50);

        // Continuous: three windows, continuous dropped during the third.
        set_pattern(2, 2, 2, 2);
        continuous = 1'b1;
        issue(20, pack(5, 5, 5, 5), 4'b0000, 3, c);
        wait_until(c + 52);
        continuous = 1'b0;
        drain(100);
        repeat (30) @(negedge clk);
        check("busy_after_cont", 64'(busy), 64'd0);

        // Reset in the middle of a window aborts it without a strobe.
        set_pattern(2, 0, 0, 0);
        @(posedge clk);
        #1;
        gate_len = 16'd100;
        start = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(c + 50);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_value", 64'(value_out), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        repeat (10) @(negedge clk);
        issue(100, pack(25, 0, 0, 0), 4'b0000, 1, c);
        drain(200);

        // gate_len=0 behaves as a one-cycle window.
        set_pattern(0, 0, 0, 0);
        issue(0, pack(0, 0, 0, 0), 4'b0000, 1, c);
        drain(10);
        repeat (10) @(negedge clk);
        check("final_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ring_osc_freq_counter.md
Name: ring_osc_freq_counter

Overview:
Multi-channel ring-oscillator frequency counter, successor to the single-channel counting circuit. Each channel synchronises an asynchronous ring-oscillator output, detects rising edges, and counts them over a programmable gate window of clk cycles. Supports single-shot and continuous measurement, with per-channel saturation/overflow flags and a one-cycle result-valid strobe. Sits between the ring-oscillator array and the readout/host logic.

Parameters:
NUM_CH, 4, number of ring-oscillator channels
CNT_W, 16, edge-counter and result width per channel
GATE_W, 16, width of gate-window length
SYNC_STAGES, 2, synchroniser flops per channel (min 2)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
ring_in  input  NUM_CH  asynchronous ring-oscillator outputs, bit i = channel i
gate_len  input  GATE_W  window length in clk cycles; sampled at window start
start  input  1  begin a measurement (sampled in IDLE only)
continuous  input  1  1 = re-arm automatically after each window
busy  output  1  high while a window is running (MEASURE or DONE)
value_out  output  NUM_CH*CNT_W  result; channel i at bits [i*CNT_W +: CNT_W]
overflow  output  NUM_CH  channel saturated during the last window
valid  output  1  one-cycle strobe: value_out/overflow updated

Behaviour:
- Reset (sampled on clk rising edge while rst=1): state=IDLE; busy=0, valid=0, value_out=0, overflow=0; counters, gate counter and all synchroniser/edge flops cleared. rst mid-window aborts it; no valid is produced.
- Per channel: ring_in[i] -> SYNC_STAGES flops -> edge pulse = sync_out & ~sync_out_d. Pulse lags ring_in by SYNC_STAGES+1 cycles. Accurate only for f_ring < f_clk/2; higher frequencies alias (documented limit, no detection).
- States: IDLE, MEASURE, DONE.
- IDLE: start=1 in cycle t -> MEASURE from cycle t+1; counters cleared to 0, gate counter loaded with max(gate_len,1) (gate_len=0 treated as 1); busy=1 from t+1.
- MEASURE: lasts exactly N = max(gate_len,1) cycles (t+1..t+N). Each cycle, every channel with an edge pulse increments its counter. Gate counter decrements; in the last cycle, value_out/overflow load the final count including that cycle's pulse; state -> DONE.
- DONE (cycle t+N+1): valid=1 for this cycle only; value_out stable. Edges in DONE are not counted. Next: continuous=1 -> MEASURE (counters cleared, gate_len re-sampled); else IDLE, busy=0 next cycle.
- Saturation: counter at 2^CNT_W-1 holds on further pulses; channel's sticky overflow flag set for the window, cleared at next window start.
- value_out/overflow hold last result until next window completes or reset.
- start while busy: ignored. gate_len changes mid-window: no effect on current window. continuous deasserted mid-window: current window completes with valid, then IDLE.
- start and rst simultaneous: rst wins.

Decomposition:
- Package ring_osc_pkg: state enum (IDLE/MEASURE/DONE), minimum SYNC_STAGES constant, channel-slice helper function for value_out packing.
- Sub-module ring_edge_sync: SYNC_STAGES-flop synchroniser + rising-edge detector, one instance per channel via generate; counting and FSM stay in the top.

Test Plan:
- Single-shot: ring_in[0] toggles every 2 clk cycles (edge every 4), others 0; gate_len=100; start at cycle t -> valid only at t+101; ch0=25, ch1..3=0; overflow=0; busy low from t+102.
- Saturation (CNT_W=8): ring_in[1] toggles every clk (edge every 2 cycles), gate_len=600 -> ch1=255, overflow[1]=1, others 0; next window gate_len=10 -> ch1=5, overflow[1]=0.
- Continuous: gate_len=20, edge every 4 cycles on all channels, continuous=1 -> valid every 21 cycles, each result 5 per channel; drop continuous mid-window -> that window completes with valid, then busy=0, no further valid.
- Ignore rules: start pulsed and gate_len changed to 5 during a 100-cycle window -> window still 100 cycles, result unchanged from single-shot case, no extra window.
- Reset mid-window: rst high 1 cycle at window cycle 50 -> next cycle busy=0, valid=0, value_out=0, overflow=0, no valid strobe; fresh start reproduces single-shot result exactly.
- gate_len=0: start -> 1-cycle window, valid at t+2; count is 0 or 1 matching the pulse in that cycle.
